fft_output_unloader: RTL

FFT_OUTPUT_UNLOADER -- requirements
Module: fft_output_unloader

---
 rtl/fft_output_unloader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fft_output_unloader.sv
// Streams the 64 FFT results out of two bit-reversed result banks in natural order,
// through a 2-entry FIFO with ready/valid backpressure.
module fft_output_unloader #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   output logic              re_b0,
   output logic [4:0]        raddr_b0,
   input  logic [DATA_W-1:0] rdata_b0,
   output logic              re_b1,
   output logic [4:0]        raddr_b1,
   input  logic [DATA_W-1:0] rdata_b1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [5:0]        out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err_overrun
);

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e            state_q;
   logic [5:0]        rd_cnt_q;
   logic              inflight_q;
   logic              inflight_bank_q;
   logic              inflight_last_q;
   logic [5:0]        inflight_idx_q;
   logic [DATA_W-1:0] fifo_data_q [2];
   logic [5:0]        fifo_idx_q  [2];
   logic [1:0]        fifo_last_q;
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        fifo_cnt_q;
   logic [1:0]        fifo_cnt_d;

   logic       pop;
   logic       push;
   logic       issue;
   logic       rd_bank;
   logic [5:0] rd_pos;
   logic [2:0] level;

   assign pop  = out_valid & out_ready;
   assign push = inflight_q;

   // Occupancy after this cycle's pop; reads in flight count as already queued.
   assign level = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = (state_q == StRead) && (level < 3'd2);

   assign rd_pos  = {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2], rd_cnt_q[3], rd_cnt_q[4], rd_cnt_q[5]};
   assign rd_bank = ^rd_cnt_q;

   assign re_b0    = issue & ~rd_bank;
   assign re_b1    = issue & rd_bank;
   assign raddr_b0 = re_b0 ? rd_pos[5:1] : 5'd0;
   assign raddr_b1 = re_b1 ? rd_pos[5:1] : 5'd0;

   assign out_valid   = (fifo_cnt_q != 2'd0);
   assign out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign out_index   = out_valid ? fifo_idx_q[rd_ptr_q] : 6'd0;
   assign out_last    = out_valid & fifo_last_q[rd_ptr_q];
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDrain) & pop & out_last;
   assign err_overrun = start & busy;

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + 2'd1;
      end else if (!push && pop) begin
         fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= StIdle;
         rd_cnt_q <= 6'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StRead;
                  rd_cnt_q <= 6'd0;
               end
            end
            StRead: begin
               if (issue) begin
                  if (rd_cnt_q == 6'd63) begin
                     state_q <= StDrain;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + 6'd1;
                  end
               end
            end
            StDrain: begin
               if (done) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Bank data arrives one cycle after issue; the bank choice rides along with it.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         inflight_q      <= 1'b0;
         inflight_bank_q <= 1'b0;
         inflight_last_q <= 1'b0;
         inflight_idx_q  <= 6'd0;
         fifo_data_q[0]  <= '0;
         fifo_data_q[1]  <= '0;
         fifo_idx_q[0]   <= 6'd0;
         fifo_idx_q[1]   <= 6'd0;
         fifo_last_q     <= 2'b00;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         fifo_cnt_q      <= 2'd0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            inflight_bank_q <= rd_bank;
            inflight_last_q <= (rd_cnt_q == 6'd63);
            inflight_idx_q  <= rd_cnt_q;
         end
         if (push) begin
            fifo_data_q[wr_ptr_q] <= inflight_bank_q ? rdata_b1 : rdata_b0;
            fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

endmodule
